// File: rtl/mem_copy_dma.sv
// mem_copy_dma
//   Data-port initiator that copies len 32-bit words from src_addr to dst_addr
//   by issuing alternating read (MOE) and write (MWR) cycles, ascending order.
//   Requests that are misaligned or run past MEM_WORDS are rejected with err.
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   start                   request, sampled only while idle
//   src_addr, dst_addr      word-aligned byte addresses
//   len                     word count (0 allowed)
//   MA, MWD, MWR, MOE       memory address / write data / write / read enables
//   MRD                     memory read data (valid in the MOE cycle)
//   busy, done, err         in-progress flag, completion pulse, rejection pulse
module mem_copy_dma #(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned LEN_W     = 6
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic [31:0]      MA,
  output logic [31:0]      MWD,
  output logic             MWR,
  output logic             MOE,
  input  logic [31:0]      MRD,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_i;

  logic [32:0]      w_src_end;
  logic [32:0]      w_dst_end;
  logic             w_ok;
  logic [LEN_W-1:0] w_i_nxt;
  logic             w_last;

  // 33-bit sums so a huge address cannot wrap back into range
  assign w_src_end = {3'b000, src_addr[31:2]} + 33'(len);
  assign w_dst_end = {3'b000, dst_addr[31:2]} + 33'(len);
  assign w_ok      = (src_addr[1:0] == 2'b00) && (dst_addr[1:0] == 2'b00) &&
                     (w_src_end <= 33'(MEM_WORDS)) && (w_dst_end <= 33'(MEM_WORDS));
  assign w_i_nxt   = r_i + LEN_W'(1);
  assign w_last    = (r_i == r_len - LEN_W'(1));

  // Outputs are loaded with the values belonging to the state being entered,
  // so every memory-side signal comes straight from a flop.
  // MWD doubles as the data register: it captures MRD on the READ edge and
  // holds it through WRITE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_i     <= '0;
      MA      <= '0;
      MWD     <= '0;
      MWR     <= 1'b0;
      MOE     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!w_ok) begin
              err <= 1'b1;
            end else begin
              r_src <= src_addr;
              r_dst <= dst_addr;
              r_len <= len;
              r_i   <= '0;
              if (len == '0) begin
                done    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                MA      <= src_addr;
                MOE     <= 1'b1;
                busy    <= 1'b1;
                r_state <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          MWD     <= MRD;
          MA      <= r_dst + (32'(r_i) << 2);
          MOE     <= 1'b0;
          MWR     <= 1'b1;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          MWR <= 1'b0;
          MWD <= '0;
          if (w_last) begin
            MA      <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_i     <= w_i_nxt;
            MA      <= r_src + (32'(w_i_nxt) << 2);
            MOE     <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
module tb_mem_copy_dma;
  localparam int unsigned MEMW  = 32;
  localparam int unsigned LEN_W = 6;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic [31:0]      MA, MWD, MRD;
  logic             MWR, MOE, busy, done, err;

  logic [31:0] mem     [MEMW];
  logic [31:0] ref_mem [MEMW];

  int checks   = 0;
  int failures = 0;

  mem_copy_dma #(.MEM_WORDS(MEMW), .LEN_W(LEN_W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .MA(MA), .MWD(MWD), .MWR(MWR), .MOE(MOE), .MRD(MRD),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Word-addressed test memory: combinational read, write on posedge
  assign MRD = MOE ? mem[MA[6:2]] : 32'h0;
  always @(posedge clk) if (MWR) mem[MA[6:2]] = MWD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int unsigned idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  task automatic chk_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < MEMW; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_MA"}, MA, 32'h0);
    chk({tag, "_MWD"}, MWD, 32'h0);
    chk({tag, "_MWR"}, 32'(MWR), 32'h0);
    chk({tag, "_MOE"}, 32'(MOE), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  // One request, checked cycle by cycle against the copy rules.
  // poke >= 0 re-asserts start with other addresses during that cycle.
  task automatic xfer(input logic [31:0] s, input logic [31:0] d,
                      input int unsigned l, input int poke);
    logic        ok;
    logic [31:0] exp_d[$];
    int unsigned total, k;
    logic        e_busy, e_moe, e_mwr, e_done, e_err;
    logic [31:0] e_ma;
    ok = (s[1:0] == 2'b00) && (d[1:0] == 2'b00) &&
         (longint'(s >> 2) + l <= MEMW) && (longint'(d >> 2) + l <= MEMW);
    if (ok) begin
      for (int unsigned j = 0; j < l; j++) begin
        exp_d.push_back(ref_mem[(s >> 2) + j]);
        ref_mem[(d >> 2) + j] = ref_mem[(s >> 2) + j];
      end
    end
    @(negedge clk);
    src_addr = s; dst_addr = d; len = LEN_W'(l); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    src_addr = $urandom; dst_addr = $urandom; len = LEN_W'($urandom);
    total = ok ? 2 * l + 2 : 2;
    for (int c = 0; c < int'(total); c++) begin
      @(negedge clk);
      e_busy = 0; e_moe = 0; e_mwr = 0; e_done = 0; e_err = 0; e_ma = '0;
      k = c / 2;
      if (!ok) begin
        e_err = (c == 0);
      end else if (c < int'(2 * l)) begin
        e_busy = 1;
        if (c % 2 == 0) begin e_moe = 1; e_ma = s + 32'(4 * k); end
        else begin e_mwr = 1; e_ma = d + 32'(4 * k); end
      end else if (c == int'(2 * l)) begin
        e_done = 1;
      end
      chk("busy", 32'(busy), 32'(e_busy));
      chk("MOE", 32'(MOE), 32'(e_moe));
      chk("MWR", 32'(MWR), 32'(e_mwr));
      chk("MA", MA, e_ma);
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      if (e_mwr) chk("MWD", MWD, exp_d[k]);
      if (!e_busy) chk("MWD_idle", MWD, 32'h0);
      if (c == poke) begin
        src_addr = 32'h10; dst_addr = 32'h60; len = LEN_W'(2); start = 1'b1;
      end
      if (c == poke + 1) start = 1'b0;
    end
    chk_mem("mem_contents");
  endtask

  initial begin
    logic [31:0] s, d;
    int unsigned l, sel;
    for (int i = 0; i < MEMW; i++) set_word(i, $urandom);

    // Reset held with start asserted
    start = 1'b1; src_addr = 32'h4; dst_addr = 32'h40; len = LEN_W'(3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    start = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");

    // Basic copy
    set_word(1, 32'h0A); set_word(2, 32'h38); set_word(3, 32'h0);
    xfer(32'h04, 32'h40, 3, -1);
    chk("basic_w16", mem[16], 32'h0A);
    chk("basic_w17", mem[17], 32'h38);
    chk("basic_w18", mem[18], 32'h0);

    // Zero length
    xfer(32'h00, 32'h00, 0, -1);

    // Overlap replicates source data
    set_word(1, 32'h0A); set_word(2, 32'h38);
    xfer(32'h04, 32'h08, 2, -1);
    chk("ovl_w2", mem[2], 32'h0A);
    chk("ovl_w3", mem[3], 32'h0A);

    // Rejections and positive control at the range boundary
    xfer(32'h06, 32'h40, 1, -1);
    xfer(32'h74, 32'h00, 4, -1);
    xfer(32'h00, 32'h7C, 2, -1);
    xfer(32'h00, 32'h06, 1, -1);
    xfer(32'hFFFF_FFFC, 32'h00, 2, -1);
    xfer(32'h74, 32'h00, 3, -1);
    xfer(32'h00, 32'h00, 32, -1);

    // Start while busy is ignored
    xfer(32'h20, 32'h50, 3, 1);

    // Random requests
    for (int t = 0; t < 25; t++) begin
      l = $urandom_range(0, 8);
      s = 32'($urandom_range(0, MEMW - l)) << 2;
      d = 32'($urandom_range(0, MEMW - l)) << 2;
      sel = $urandom_range(0, 9);
      if (sel == 0) s = s | 32'($urandom_range(1, 3));
      else if (sel == 1) d = 32'($urandom_range(MEMW - l + 1, MEMW + 8)) << 2;
      xfer(s, d, l, (sel == 2) ? 1 : -1);
    end

    // Reset after the first WRITE aborts the copy
    ref_mem[20] = ref_mem[8];
    @(negedge clk);
    src_addr = 32'h20; dst_addr = 32'h50; len = LEN_W'(3); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1 chk_quiet("abort");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_MWR", 32'(MWR), 32'h0);
    end
    chk_mem("abort_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
